// File: rtl/imem_loader.sv
// Streams a length-prefixed image of big-endian words into instruction memory and holds the CPU in reset until the load completes.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic [31:0]       load_base,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERROR
  } state_t;

  localparam logic [ADDR_W:0] ONE = 1;

  state_t          state;
  logic [15:0]     len;
  logic [1:0]      byte_cnt;
  logic [23:0]     asm_q;
  logic            acc;
  logic [15:0]     hdr_len;
  logic [ADDR_W:0] wl_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      csum_q;
`endif

  assign load_base = TEXT_BASE;
  assign acc       = in_valid && in_ready;
  assign hdr_len   = {len[15:8], in_data};
  assign wl_next   = words_loaded + ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LEN_HI;
      len          <= '0;
      byte_cnt     <= '0;
      asm_q        <= '0;
      in_ready     <= 1'b0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      im_we    <= 1'b0;
      in_ready <= 1'b1;
      case (state)
        LEN_HI: begin
          if (acc) begin
            len[15:8] <= in_data;
            state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (acc) begin
            len[7:0] <= in_data;
            if (hdr_len == 16'h0000) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= CSUM;
`else
              state    <= DONE;
              done     <= 1'b1;
              in_ready <= 1'b0;
`endif
            end else if (32'(hdr_len) > DEPTH) begin
              state    <= ERROR;
              error    <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (acc) begin
            byte_cnt <= byte_cnt + 2'd1;
            asm_q    <= {asm_q[15:0], in_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q   <= csum_q ^ in_data;
`endif
            if (byte_cnt == 2'd3) begin
              im_we        <= 1'b1;
              im_wdata     <= {asm_q, in_data};
              im_addr      <= words_loaded[ADDR_W-1:0];
              words_loaded <= wl_next;
              // Leave DATA on the same edge that launches the final write.
              if (16'(wl_next) == len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state    <= CSUM;
`else
                state    <= DONE;
                done     <= 1'b1;
                in_ready <= 1'b0;
`endif
              end
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (acc) begin
            in_ready <= 1'b0;
            if (in_data == csum_q) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end
`endif
        DONE: begin
          in_ready <= 1'b0;
          done     <= 1'b1;
          cpu_rst  <= 1'b0;
        end
        ERROR: begin
          in_ready <= 1'b0;
          error    <= 1'b1;
        end
        default: begin
          state    <= ERROR;
          error    <= 1'b1;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected IM writes are queued at stimulus time and a monitor pops them on every im_we.
module tb_imem_loader;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
  localparam int LIM    = 200;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rst;
  logic [31:0]       load_base;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.TEXT_BASE(32'h0000_3000), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .cpu_rst(cpu_rst),
    .load_base(load_base), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int gap_lo  = 0;
  int gap_hi  = 0;
  logic [41:0] exp_q[$];
  logic [31:0] img [0:DEPTH-1];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && im_we) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", im_addr, im_wdata);
      end else begin
        logic [41:0] e;
        e = exp_q.pop_front();
        check("im_write", {22'h0, im_addr, im_wdata}, {22'h0, e});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({in_ready, im_we, im_addr, im_wdata, cpu_rst, done, error, words_loaded}),
          64'({1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, 1'b0, 11'h0}));
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    repeat ($urandom_range(gap_hi, gap_lo)) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < LIM) begin
      @(negedge clk);
      t++;
    end
    if (t >= LIM) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: got in_ready=0 for %0d cycles expected 1", t);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic run_load(input logic [15:0] len, input logic [7:0] cdelta);
    logic [7:0] x;
    logic       fits;
    logic       ok;
    int         t;
    logic [31:0] w;
    x = 8'h00;
    fits = (32'(len) <= DEPTH);
`ifdef IMEM_LOADER_CHECKSUM_EN
    ok = fits && (cdelta == 8'h00);
`else
    ok = fits;
`endif
    do_reset();
    send(len[15:8]);
    send(len[7:0]);
    if (fits) begin
      for (int i = 0; i < int'(len); i++) begin
        w = img[i];
        exp_q.push_back({10'(i), w});
        for (int b = 3; b >= 0; b--) begin
          send(w[8*b +: 8]);
          x = x ^ w[8*b +: 8];
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(x ^ cdelta);
`endif
    end
    @(negedge clk);
    t = 0;
    while (!(done || error) && t < LIM) begin
      @(negedge clk);
      t++;
    end
    if (t >= LIM) begin
      n_tests++;
      n_fail++;
      $display("FAIL end_timeout: got done=0 error=0 after %0d cycles expected one set", t);
    end
    check("done", 64'(done), 64'(ok));
    check("error", 64'(error), 64'(!ok));
    check("cpu_rst_entry", 64'(cpu_rst), 64'(1));
    check("in_ready_end", 64'(in_ready), 64'(0));
    check("words_loaded", 64'(words_loaded), fits ? 64'(len) : 64'(0));
    @(negedge clk);
    check("cpu_rst_after", 64'(cpu_rst), 64'(!ok));
    check("load_base", 64'(load_base), 64'h3000);
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("sticky", 64'({done, error, in_ready}), 64'({ok, !ok, 1'b0}));
    check("writes_left", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;

    img[0] = 32'h2010_0001;
    img[1] = 32'h2011_0002;
    run_load(16'd2, 8'h00);

    gap_lo = 3; gap_hi = 3;
    run_load(16'd2, 8'h00);
    gap_lo = 0; gap_hi = 0;

    run_load(16'd0, 8'h00);
    run_load(16'h0401, 8'h00);

`ifdef IMEM_LOADER_CHECKSUM_EN
    run_load(16'd2, 8'h07);
`endif

    // Abort after one complete word and two bytes of the next.
    do_reset();
    exp_q.push_back({10'd0, 32'hA1B2_C3D4});
    send(8'h00); send(8'h03);
    send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4); send(8'hE5); send(8'hF6);
    repeat (2) @(negedge clk);
    check("midload_words", 64'(words_loaded), 64'(1));
    rst = 1'b1;
    #1;
    check("midload_reset", 64'({in_ready, im_we, im_addr, im_wdata, cpu_rst, done, error, words_loaded}),
          64'({1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, 1'b0, 11'h0}));
    check("midload_writes", 64'(exp_q.size()), 64'(0));
    img[0] = 32'h1234_5678;
    run_load(16'd1, 8'h00);

    for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
    run_load(16'(DEPTH), 8'h00);

    for (int r = 0; r < 8; r++) begin
      gap_lo = 0;
      gap_hi = 2;
      for (int i = 0; i < 16; i++) img[i] = $urandom;
      run_load(16'($urandom_range(16, 1)), 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
